uart_mmio_tx: RTL and testbench

UART_MMIO_TX -- requirements
Module: uart_mmio_tx

---
 rtl/uart_pkg.sv | 26 ++
 rtl/sync_fifo.sv | 53 +++++
 rtl/uart_mmio_tx.sv | 168 ++++++++++++++++
 tb/tb_uart_mmio_tx.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the MMIO UART transmitter: FSM states, register offsets, frame sizes.
// Latency: n/a (types and constants only).
// Backpressure: n/a. Macro UART_MMIO_PARITY_EN adds the PARITY state and the 11-bit frame.
package uart_pkg;

    localparam logic [31:0] DATA_OFS  = 32'h0000_0000;
    localparam logic [31:0] CTRL_OFS  = 32'h0000_0004;
    localparam int          DATA_BITS = 8;

`ifdef UART_MMIO_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef UART_MMIO_PARITY_EN
        ST_PARITY = 3'd4,
`endif
        ST_STOP   = 3'd3
    } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO, WIDTH bits x 2**AW entries, head word visible combinationally on rdata_o.
// Latency: a push is visible on empty_o/rdata_o one cycle later.
// Backpressure: push on full is ignored unless a pop happens in the same cycle; pop on empty is ignored.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int AW    = 3
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int DEPTH = 2 ** AW;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q;
    logic [AW-1:0]    rptr_q;
    logic [AW:0]      cnt_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign rdata_o = mem_q[rptr_q];
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    // Storage array: written only on an accepted push, no reset needed.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

    // Pointers and occupancy; reset empties the FIFO.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
            cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/uart_mmio_tx.sv
// MMIO-fed UART transmitter: DATA writes queue bytes, FSM serialises 8N1 (8E1 with UART_MMIO_PARITY_EN).
// Latency: a write into an empty FIFO while idle drops tx two cycles later; frames repeat with a 1-cycle gap.
// Backpressure: none to the core; a DATA write to a full FIFO with no pop is dropped and sets sticky overflow.
module uart_mmio_tx
    import uart_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_8000,
    parameter int          CLK_DIV   = 434,
    parameter int          FIFO_AW   = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_data,
    input  logic        mem_we,
    output logic        tx,
    output logic        busy,
    output logic        overflow
);

    localparam int            CW          = $clog2(CLK_DIV);
    localparam logic [CW-1:0] BAUD_RELOAD = CW'(CLK_DIV - 1);

    tx_state_e     state_q, state_d;
    logic [CW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;
    logic          overflow_q, overflow_d;
`ifdef UART_MMIO_PARITY_EN
    logic          parity_q, parity_d;
`endif

    logic       data_wr;
    logic       ctrl_clr;
    logic       ovf_evt;
    logic       fifo_push;
    logic       fifo_pop;
    logic       fifo_full;
    logic       fifo_empty;
    logic [7:0] fifo_rdata;
    logic       baud_zero;
    logic       unused_data;

    assign data_wr     = mem_we && (mem_addr == BASE_ADDR + DATA_OFS);
    assign ctrl_clr    = mem_we && (mem_addr == BASE_ADDR + CTRL_OFS) && mem_data[0];
    // A full FIFO still takes the byte when the FSM pops in the same cycle.
    assign fifo_push   = data_wr && (!fifo_full || fifo_pop);
    assign ovf_evt     = data_wr && fifo_full && !fifo_pop;
    // A simultaneous overflow event wins over a clear.
    assign overflow_d  = ovf_evt | (overflow_q & ~ctrl_clr);
    assign baud_zero   = (baud_q == '0);
    assign unused_data = ^mem_data[31:8];

    assign tx       = tx_q;
    assign overflow = overflow_q;
    assign busy     = (state_q != ST_IDLE) | ~fifo_empty;

    sync_fifo #(
        .WIDTH (8),
        .AW    (FIFO_AW)
    ) u_fifo (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .push_i  (fifo_push),
        .wdata_i (mem_data[7:0]),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Next state, bit timing and shift register; tx is registered from the next-state values.
    always_comb begin
        state_d  = state_q;
        baud_d   = baud_zero ? baud_q : baud_q - 1'b1;
        bit_d    = bit_q;
        shift_d  = shift_q;
        fifo_pop = 1'b0;
`ifdef UART_MMIO_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_rdata;
`ifdef UART_MMIO_PARITY_EN
                    parity_d = ^fifo_rdata;
`endif
                    baud_d   = BAUD_RELOAD;
                    state_d  = ST_START;
                end
            end
            ST_START: begin
                if (baud_zero) begin
                    baud_d  = BAUD_RELOAD;
                    bit_d   = '0;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (baud_zero) begin
                    baud_d = BAUD_RELOAD;
                    if (bit_q == 3'(DATA_BITS - 1)) begin
`ifdef UART_MMIO_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                    end
                end
            end
`ifdef UART_MMIO_PARITY_EN
            ST_PARITY: begin
                if (baud_zero) begin
                    baud_d  = BAUD_RELOAD;
                    state_d = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (baud_zero) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        case (state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shift_d[0];
`ifdef UART_MMIO_PARITY_EN
            ST_PARITY: tx_d = parity_d;
`endif
            default:   tx_d = 1'b1;
        endcase
    end

    // State register; reset aborts any frame and forces the line idle high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            baud_q     <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
            overflow_q <= 1'b0;
`ifdef UART_MMIO_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            overflow_q <= overflow_d;
`ifdef UART_MMIO_PARITY_EN
            parity_q   <= parity_d;
`endif
        end
    end

endmodule

// File: tb/tb_uart_mmio_tx.sv
// Self-checking bench for uart_mmio_tx (CLK_DIV=4, FIFO_AW=2) against a queue-based line model.
// Latency: n/a.
// Backpressure: n/a. Honours UART_MMIO_PARITY_EN for the expected frame shape.
module tb_uart_mmio_tx;

    localparam logic [31:0] BASE    = 32'h0000_8000;
    localparam int          CLK_DIV = 4;
    localparam int          FIFO_AW = 2;
    localparam int          DEPTH   = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_data = '0;
    logic        mem_we = 1'b0;
    logic        tx;
    logic        busy;
    logic        overflow;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Model state: bytes waiting in the FIFO, per-cycle line values still to come, sticky overflow.
    logic [7:0] mq[$];
    logic       exp_bits[$];
    logic       m_ovf  = 1'b0;
    logic       m_tx   = 1'b1;
    logic       m_busy = 1'b0;

    uart_mmio_tx #(
        .BASE_ADDR (BASE),
        .CLK_DIV   (CLK_DIV),
        .FIFO_AW   (FIFO_AW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .mem_addr (mem_addr),
        .mem_data (mem_data),
        .mem_we   (mem_we),
        .tx       (tx),
        .busy     (busy),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog cyc=%0d observed=running required=finished", cyc);
        $fatal(1, "simulation time limit reached");
    end

    task automatic check(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
        end
    endtask

    // Appends the full line waveform of one frame plus the single idle cycle that follows it.
    task automatic model_frame(input logic [7:0] b);
        for (int i = 0; i < CLK_DIV; i++) exp_bits.push_back(1'b0);
        for (int k = 0; k < 8; k++)
            for (int i = 0; i < CLK_DIV; i++) exp_bits.push_back(b[k]);
`ifdef UART_MMIO_PARITY_EN
        for (int i = 0; i < CLK_DIV; i++) exp_bits.push_back(^b);
`endif
        for (int i = 0; i < CLK_DIV; i++) exp_bits.push_back(1'b1);
        exp_bits.push_back(1'b1);
    endtask

    // One clock edge of the model, using the bus inputs present during the cycle.
    task automatic model_edge();
        logic ovf_evt;
        logic clr;
        ovf_evt = 1'b0;
        if (exp_bits.size() == 0 && mq.size() > 0) model_frame(mq.pop_front());
        if (mem_we && mem_addr == BASE) begin
            if (mq.size() < DEPTH) mq.push_back(mem_data[7:0]);
            else ovf_evt = 1'b1;
        end
        clr   = mem_we && (mem_addr == BASE + 32'd4) && mem_data[0];
        m_ovf = ovf_evt | (m_ovf & ~clr);
        m_tx  = (exp_bits.size() > 0) ? exp_bits.pop_front() : 1'b1;
        m_busy = (exp_bits.size() > 0) || (mq.size() > 0);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        cyc++;
        check("tx", tx, m_tx);
        check("busy", busy, m_busy);
        check("overflow", overflow, m_ovf);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        mem_we   = 1'b1;
        mem_addr = a;
        mem_data = d;
        step();
        mem_we   = 1'b0;
        mem_addr = '0;
        mem_data = '0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_bits.size() > 0 || mq.size() > 0) && n < 2000) begin
            step();
            n++;
        end
        idle(2);
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] d;
        int          len;
        int          sel;

        // Reset values while rst_n is held low.
        repeat (3) @(posedge clk);
        #1;
        check("rst_tx", tx, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_overflow", overflow, 1'b0);
        rst_n = 1'b1;
        idle(3);

        // Single byte 0x55: two-cycle latency, alternating bits, 40-cycle frame, busy drops after.
        wr(BASE, 32'h0000_0055);
        drain();

        // Five bytes back to back: first popped at once, four fill the FIFO, no overflow.
        for (int i = 1; i <= 5; i++) wr(BASE, 32'(i));
        drain();

        // Six bytes: the sixth is dropped, overflow set, then cleared through CTRL.
        for (int i = 0; i < 6; i++) wr(BASE, 32'h10 + 32'(i));
        idle(3);
        wr(BASE + 32'd4, 32'h0000_0001);
        drain();

        // Write to an unmapped register: no effect.
        wr(BASE + 32'd8, 32'h0000_00AA);
        idle(10);

        // Parity-relevant bytes (odd and even popcount).
        wr(BASE, 32'h0000_0007);
        drain();
        wr(BASE, 32'h0000_0003);
        drain();

        // Random bursts mixing DATA, CTRL and stray writes with random upper bits.
        for (int r = 0; r < 10; r++) begin
            len = $urandom_range(1, 7);
            for (int j = 0; j < len; j++) begin
                sel = $urandom_range(0, 9);
                d   = $urandom();
                if (sel < 7) begin
                    a = BASE;
                end else if (sel < 9) begin
                    a = BASE + 32'd4;
                end else begin
                    a = $urandom();
                    if (a == BASE || a == BASE + 32'd4) a = BASE + 32'd12;
                end
                wr(a, d);
            end
            idle($urandom_range(0, 60));
            if (r % 3 == 2) drain();
        end
        drain();

        // Reset during data bit 3 of 0xFF with two bytes queued behind it.
        wr(BASE, 32'h0000_00FF);
        wr(BASE, 32'h0000_0011);
        wr(BASE, 32'h0000_0022);
        idle(16);
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset_tx", tx, 1'b1);
        check("midreset_busy", busy, 1'b0);
        check("midreset_overflow", overflow, 1'b0);
        exp_bits.delete();
        mq.delete();
        m_ovf = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(60);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
